// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: oversamples an 8-bit parallel camera port in the Wishbone
// clock domain, packs four pixel bytes per 32-bit word and pushes the words
// into the FIFO, with frame/overflow status for the register file.
module cam_capture_ctrl #(
  parameter logic [7:0]  PAD_BYTE    = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        PCLK_i,
  input  logic        VSYNC_i,
  input  logic        HREF_i,
  input  logic [7:0]  CAM_D_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        continuous_i,
  input  logic [3:0]  fifo_push_flag_i,
  output logic        fifo_push_o,
  output logic [31:0] fifo_din_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        overflow_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] word_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0]      pclk_sr, vsync_sr, href_sr;
  logic [SYNC_STAGES-1:0][7:0] d_sr;
  logic                        pclk_s, vsync_s, href_s;
  logic [7:0]                  d_s;
  logic                        pclk_d, vsync_d, href_d;

  logic        stb_q, hfall_q, vrise_q, vfall_q;
  logic [7:0]  byte_q;

  logic [31:0] pack_q;
  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic        pend_q;
  logic        frame_done_q;
  logic        overflow_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] word_cnt_q;
  logic [31:0] flush_word;

  assign pclk_s  = pclk_sr[SYNC_STAGES-1];
  assign vsync_s = vsync_sr[SYNC_STAGES-1];
  assign href_s  = href_sr[SYNC_STAGES-1];
  assign d_s     = d_sr[SYNC_STAGES-1];

  // Synchroniser chains for the asynchronous camera pins.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      pclk_sr  <= '0;
      vsync_sr <= '0;
      href_sr  <= '0;
      d_sr     <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[SYNC_STAGES-2:0], PCLK_i};
      vsync_sr <= {vsync_sr[SYNC_STAGES-2:0], VSYNC_i};
      href_sr  <= {href_sr[SYNC_STAGES-2:0], HREF_i};
      d_sr     <= {d_sr[SYNC_STAGES-2:0], CAM_D_i};
    end
  end

  // Edge detection; all events are registered together so the byte strobe
  // and the HREF/VSYNC edges keep their relative order.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      pclk_d  <= 1'b0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      stb_q   <= 1'b0;
      hfall_q <= 1'b0;
      vrise_q <= 1'b0;
      vfall_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      pclk_d  <= pclk_s;
      vsync_d <= vsync_s;
      href_d  <= href_s;
      stb_q   <= pclk_s & ~pclk_d & href_s & vsync_s;
      hfall_q <= ~href_s & href_d;
      vrise_q <= vsync_s & ~vsync_d;
      vfall_q <= ~vsync_s & vsync_d;
      byte_q  <= d_s;
    end
  end

  // State register.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; abort overrides everything, including start.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = ARMED;
        ARMED:   if (vrise_q) state_d = ACTIVE;
        ACTIVE:  if (vfall_q) state_d = continuous_i ? ARMED : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Partial word: keep the lanes already written, pad the rest.
  always_comb begin
    flush_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      flush_word[8*i +: 8] = (i < 32'(idx_q)) ? pack_q[8*i +: 8] : PAD_BYTE;
    end
  end

  // Packing, push request, counters and status.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      pack_q       <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= '0;
      word_cnt_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
      if (pend_q) begin
        if (fifo_push_flag_i == 4'h0)  overflow_q <= 1'b1;
        else if (word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (abort_i) begin
        idx_q  <= '0;
        pack_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              overflow_q <= 1'b0;
              word_cnt_q <= '0;
              idx_q      <= '0;
            end
          end
          ARMED: begin
            if (vrise_q) begin
              word_cnt_q <= '0;
              idx_q      <= '0;
            end
          end
          ACTIVE: begin
            if (stb_q) begin
              if (idx_q == 2'd3) begin
                word_q <= {byte_q, pack_q[23:0]};
                pend_q <= 1'b1;
                idx_q  <= '0;
              end else begin
                pack_q[{idx_q, 3'b000} +: 8] <= byte_q;
                idx_q <= idx_q + 2'd1;
              end
            end else if ((hfall_q || vfall_q) && idx_q != 2'd0) begin
              word_q <= flush_word;
              pend_q <= 1'b1;
              idx_q  <= '0;
            end
            if (vfall_q) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output drive; the push strobe is gated by FIFO full in the push cycle.
  always_comb begin
    fifo_push_o  = pend_q & (fifo_push_flag_i != 4'h0);
    fifo_din_o   = word_q;
    busy_o       = (state_q != IDLE);
    frame_done_o = frame_done_q;
    overflow_o   = overflow_q;
    frame_cnt_o  = frame_cnt_q;
    word_cnt_o   = word_cnt_q;
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: a camera model drives lines and
// frames, expected words are queued as bytes are sent and popped on each push.
module tb_cam_capture_ctrl;

  logic        WBs_CLK_i = 1'b0;
  logic        WBs_RST_i = 1'b1;
  logic        PCLK_i = 1'b0;
  logic        VSYNC_i = 1'b0;
  logic        HREF_i = 1'b0;
  logic [7:0]  CAM_D_i = '0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [3:0]  fifo_push_flag_i = 4'hF;
  logic        fifo_push_o;
  logic [31:0] fifo_din_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        overflow_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] word_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  logic [31:0] exp_q[$];

  cam_capture_ctrl #(.PAD_BYTE(8'h00), .SYNC_STAGES(2)) dut (
    .WBs_CLK_i(WBs_CLK_i), .WBs_RST_i(WBs_RST_i), .PCLK_i(PCLK_i),
    .VSYNC_i(VSYNC_i), .HREF_i(HREF_i), .CAM_D_i(CAM_D_i),
    .start_i(start_i), .abort_i(abort_i), .continuous_i(continuous_i),
    .fifo_push_flag_i(fifo_push_flag_i), .fifo_push_o(fifo_push_o),
    .fifo_din_o(fifo_din_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .overflow_o(overflow_o), .frame_cnt_o(frame_cnt_o), .word_cnt_o(word_cnt_o)
  );

  always #5 WBs_CLK_i = ~WBs_CLK_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every push against the oldest expected word.
  always @(negedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      if (fifo_push_o) begin
        if (exp_q.size() == 0) check("unexpected_push", {31'd0, fifo_push_o}, 32'd0);
        else check("push_word", fifo_din_o, exp_q.pop_front());
      end
      if (frame_done_o) fd_cnt++;
    end
  end

  task automatic cam_byte(input logic [7:0] b);
    CAM_D_i = b;
    #40 PCLK_i = 1'b1;
    #40 PCLK_i = 1'b0;
  endtask

  // One line of n bytes starting at 'first'; word number 'drop' sees FIFO full.
  task automatic cam_line(input logic [7:0] first, input int n, input bit expect_words, input int drop);
    logic [31:0] w;
    int lane;
    int widx;
    logic [7:0] b;
    bit full_now;
    w = '0; lane = 0; widx = 0;
    HREF_i = 1'b1;
    #80;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      w[8*lane +: 8] = b;
      full_now = 1'b0;
      if (lane == 3) begin
        if (widx == drop) full_now = 1'b1;
        else if (expect_words) exp_q.push_back(w);
      end
      if (i == n - 1 && lane != 3 && expect_words) exp_q.push_back(w);
      if (full_now) fifo_push_flag_i = 4'h0;
      cam_byte(b);
      if (full_now) begin
        #40 fifo_push_flag_i = 4'hF;
      end
      if (lane == 3) begin
        lane = 0; widx++; w = '0;
      end else begin
        lane++;
      end
    end
    #40 HREF_i = 1'b0;
    #160;
  endtask

  task automatic frame_begin();
    VSYNC_i = 1'b1;
    #160;
  endtask

  task automatic frame_end();
    VSYNC_i = 1'b0;
    #200;
  endtask

  task automatic pulse_start();
    @(posedge WBs_CLK_i); #1 start_i = 1'b1;
    @(posedge WBs_CLK_i); #1 start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge WBs_CLK_i); #1 abort_i = 1'b1;
    @(posedge WBs_CLK_i); #1 abort_i = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (4) @(posedge WBs_CLK_i);
    #1 WBs_RST_i = 1'b0;
    check("rst_push", {31'd0, fifo_push_o}, 32'd0);
    check("rst_din", fifo_din_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
    check("rst_overflow", {31'd0, overflow_o}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt_o}, 32'd0);

    // 1: single frame, two lines of 8 bytes
    pulse_start();
    check("t1_busy_armed", {31'd0, busy_o}, 32'd1);
    frame_begin();
    cam_line(8'h01, 8, 1'b1, -1);
    cam_line(8'h09, 8, 1'b1, -1);
    frame_end();
    check("t1_frame_done", fd_cnt, 32'd1);
    check("t1_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);
    check("t1_word_cnt", {16'd0, word_cnt_o}, 32'd4);
    check("t1_busy_idle", {31'd0, busy_o}, 32'd0);
    check("t1_drained", exp_q.size(), 32'd0);

    // 2: line of 6 bytes, partial word padded at line end
    pulse_start();
    frame_begin();
    cam_line(8'hA0, 6, 1'b1, -1);
    frame_end();
    check("t2_word_cnt", {16'd0, word_cnt_o}, 32'd2);
    check("t2_frame_cnt", {16'd0, frame_cnt_o}, 32'd2);
    check("t2_drained", exp_q.size(), 32'd0);

    // 3: FIFO full during the 2nd of 3 words
    pulse_start();
    frame_begin();
    cam_line(8'h20, 12, 1'b1, 1);
    frame_end();
    check("t3_word_cnt", {16'd0, word_cnt_o}, 32'd2);
    check("t3_overflow", {31'd0, overflow_o}, 32'd1);
    #500;
    check("t3_overflow_held", {31'd0, overflow_o}, 32'd1);
    pulse_start();
    check("t3_overflow_clr", {31'd0, overflow_o}, 32'd0);
    check("t3_busy", {31'd0, busy_o}, 32'd1);
    pulse_abort();
    check("t3_busy_abort", {31'd0, busy_o}, 32'd0);

    // 4: continuous mode, three frames
    continuous_i = 1'b1;
    pulse_start();
    frame_begin();
    cam_line(8'h30, 4, 1'b1, -1);
    frame_end();
    check("t4_busy_f1", {31'd0, busy_o}, 32'd1);
    pulse_start();
    check("t4_busy_start_ign", {31'd0, busy_o}, 32'd1);
    frame_begin();
    cam_line(8'h34, 4, 1'b1, -1);
    frame_end();
    frame_begin();
    cam_line(8'h38, 4, 1'b1, -1);
    frame_end();
    check("t4_frame_cnt", {16'd0, frame_cnt_o}, 32'd6);
    check("t4_frame_done", fd_cnt, 32'd6);
    check("t4_word_cnt", {16'd0, word_cnt_o}, 32'd1);
    check("t4_busy_f3", {31'd0, busy_o}, 32'd1);
    continuous_i = 1'b0;
    pulse_abort();
    check("t4_busy_abort", {31'd0, busy_o}, 32'd0);

    // 5: abort mid-line, then abort+start together
    pulse_start();
    frame_begin();
    HREF_i = 1'b1;
    #80;
    cam_byte(8'h55);
    cam_byte(8'h56);
    #40;
    pulse_abort();
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    HREF_i = 1'b0;
    #160;
    frame_end();
    check("t5_frame_done", fd_cnt, 32'd6);
    check("t5_frame_cnt", {16'd0, frame_cnt_o}, 32'd6);
    @(posedge WBs_CLK_i); #1 start_i = 1'b1; abort_i = 1'b1;
    @(posedge WBs_CLK_i); #1 start_i = 1'b0; abort_i = 1'b0;
    check("t5_abort_wins", {31'd0, busy_o}, 32'd0);

    // 6: arm while a frame is in progress; that frame is skipped
    VSYNC_i = 1'b1;
    #200;
    pulse_start();
    cam_line(8'h50, 4, 1'b0, -1);
    frame_end();
    check("t6_skipped_cnt", {16'd0, frame_cnt_o}, 32'd6);
    check("t6_still_armed", {31'd0, busy_o}, 32'd1);
    frame_begin();
    cam_line(8'h60, 4, 1'b1, -1);
    frame_end();
    check("t6_frame_cnt", {16'd0, frame_cnt_o}, 32'd7);
    check("t6_frame_done", fd_cnt, 32'd7);
    check("t6_word_cnt", {16'd0, word_cnt_o}, 32'd1);
    check("t6_busy", {31'd0, busy_o}, 32'd0);

    #200;
    check("final_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
